issue_select_requester: RTL
===========================

# issue_select_requester

Request-side counterpart of the issue select tree: tracks the per-entry state of an issue queue, drives the request vector into the select tree root blocks, and consumes the returned one-hot grant vector. Each grant frees the entry, or parks it in a replay window when replay is enabled, and is reported as a registered encoded index to the register-read stage. It sits between the issue queue's allocate/wakeup logic and the select tree.

## Interface
- IQ_SIZE, 32, number of issue-queue entries (power of two, ≥4)
- IQ_INDEX, clog2(IQ_SIZE), entry index width
- REPLAY_DELAY, 3, cycles an issued entry is held before freeing (only with replay enabled, 1..15)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- alloc_valid_i  in  1  allocate an entry this cycle
- alloc_idx_i  in  IQ_INDEX  entry to allocate
- ready_set_i  in  IQ_SIZE  wakeup: set ready for each marked entry
- grant_i  in  IQ_SIZE  grant vector from select tree, one-hot or zero
- replay_i  in  IQ_SIZE  return issued entries to waiting (replay builds only)
- flush_i  in  1  squash all entries
- req_o  out  IQ_SIZE  request vector to select tree
- grantValid_o  out  1  an entry issued last cycle
- grantIdx_o  out  IQ_INDEX  index of that entry
- freeCount_o  out  IQ_INDEX+1  number of FREE entries
- error_o  out  1  sticky protocol-violation flag

## Operation
- Per-entry state: FREE, WAIT (allocated, not ready), REQ (ready, requesting), ISSUED (replay only).
- req_o[i] = (state[i]==REQ); pure decode of state flops, no input paths.
- Alloc: FREE→WAIT, or FREE→REQ if ready_set_i[i] is set the same cycle. Alloc to a non-FREE entry is ignored and sets error_o.
- Wakeup: WAIT→REQ. ready_set_i on FREE/REQ/ISSUED entries is ignored (not an error).
- Grant on bit i with state REQ: REQ→FREE (no replay) or REQ→ISSUED with counter=REPLAY_DELAY. grantValid_o=1, grantIdx_o=i next cycle.
- Grant on a non-REQ entry, or grant_i with >1 bit set: no state change, grantValid_o=0, error_o set.
- Flush has priority over all other inputs: every entry→FREE, counters cleared, grantValid_o=0 next cycle. error_o is not cleared.
- freeCount_o = popcount of FREE states, registered. Updates one cycle after the state change.

## Timing
- Reset: all entries FREE, req_o=0, grantValid_o=0, grantIdx_o=0, freeCount_o=IQ_SIZE, error_o=0.
- Grant sampled at edge t; entry leaves REQ at t+1, so req_o drops the same cycle grantValid_o rises. No double grant is possible.
- Wakeup-to-request latency is 1 cycle. Alloc+wakeup in the same cycle also gives a 1-cycle latency.
- Reset asserted mid-operation clears all state immediately, with no partial issue.

## Configuration
- IQ_REPLAY_EN defined:
  - ISSUED state and per-entry 4-bit countdown exist.
  - The counter decrements every cycle; on the cycle it reaches 0 the entry goes ISSUED→FREE.
  - replay_i[i] on an ISSUED entry sends it to WAIT. Replay wins over expiry in the same cycle.
  - replay_i on a non-ISSUED entry is ignored.
- Undefined: the replay_i port is present but ignored, there is no ISSUED state, and grants free the entry directly.

## Structure
- Shared package: entry-state enum, IQ_SIZE/IQ_INDEX constants, REPLAY_DELAY default.
- Sub-module grant_encoder: one-hot→index encoder plus multi-hot/zero detection, reused by other select consumers.

## Test plan
- Reset, then alloc entry 5 with ready_set_i[5]=1 → req_o=0x20 next cycle; grant_i=0x20 → grantValid_o=1, grantIdx_o=5, req_o=0, freeCount_o=32.
- Alloc entries 0..31 without wakeup → freeCount_o=0, req_o=0. Then wakeup 0xFFFFFFFF → req_o=0xFFFFFFFF.
- grant_i=0x3 while both entries are in REQ → no state change, grantValid_o=0, error_o=1 sticky.
- Flush in the same cycle as a valid grant and an alloc → all FREE, grantValid_o=0, freeCount_o=32.
- IQ_REPLAY_EN, REPLAY_DELAY=3:
  - Grant entry 7 → freeCount_o stays unchanged for 3 cycles, then +1.
  - Repeat with replay_i[7] in cycle 2 → entry 7 goes to WAIT; wakeup → req_o[7]=1.
- Async reset pulse between edges while grantValid_o=1 → all outputs return to reset values immediately.

Source files
------------

// File: rtl/issue_select_requester_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : issue_select_requester_pkg
//  Description : Shared types and default sizing for the issue-select
//                requester and its helper blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package issue_select_requester_pkg;

  // Default issue-queue geometry; the top exposes these as overridable
  // parameters.
  localparam int IQ_SIZE_DEF      = 32;
  localparam int IQ_INDEX_DEF     = $clog2(IQ_SIZE_DEF);

  // Replay window default and the fixed width of the per-entry countdown.
  // The width bounds the legal replay delay to 1..15.
  localparam int REPLAY_DELAY_DEF = 3;
  localparam int CNT_W            = 4;

  // Per-entry lifecycle:
  //   FREE   - slot available for allocation
  //   WAIT   - allocated, operands not ready
  //   REQ    - ready, requesting the select tree
  //   ISSUED - granted, parked in the replay window (replay builds only)
  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REQ    = 2'd2,
    ST_ISSUED = 2'd3
  } entry_state_e;

endpackage : issue_select_requester_pkg
`default_nettype wire

// File: rtl/issue_select_requester_grant_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : grant_encoder
//  Description : One-hot to binary index encoder with zero and multi-hot
//                detection. Intended for any consumer of a select-tree
//                grant vector. The index output is only meaningful when
//                the vector is exactly one-hot (zero_o=0 and multi_o=0).
//  Revision    : 1.0 - initial release
// ============================================================================
module grant_encoder
  import issue_select_requester_pkg::*;
#(
  parameter int WIDTH = IQ_SIZE_DEF,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             zero_o,
  output logic             multi_o
);

  logic [WIDTH-1:0] w_vec_minus_one;

  // Clearing the lowest set bit leaves something behind only when two or
  // more bits were set.
  assign w_vec_minus_one = vec_i - {{(WIDTH-1){1'b0}}, 1'b1};
  assign zero_o          = (vec_i == '0);
  assign multi_o         = |(vec_i & w_vec_minus_one);

  // OR-reduce the positions of all set bits; exact for a one-hot vector.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec_i[i]) begin
        idx_o = idx_o | IDX_W'(i);
      end
    end
  end

endmodule : grant_encoder
`default_nettype wire

// File: rtl/issue_select_requester.sv
`default_nettype none
// ============================================================================
//  Module      : issue_select_requester
//  Description : Request side of the issue select tree. Tracks per-entry
//                issue-queue state, presents the request vector to the
//                select tree, consumes the returned grant and reports the
//                issued entry as a registered index. Also keeps a
//                registered count of free entries and a sticky protocol
//                error flag.
//  Config      : IQ_REPLAY_EN - when defined, granted entries are held in
//                an ISSUED state for REPLAY_DELAY cycles (and can be
//                replayed back to WAIT) before being freed. When undefined,
//                grants free the entry directly and replay_i is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module issue_select_requester
  import issue_select_requester_pkg::*;
#(
  parameter int IQ_SIZE      = IQ_SIZE_DEF,
  parameter int IQ_INDEX     = $clog2(IQ_SIZE),
  parameter int REPLAY_DELAY = REPLAY_DELAY_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alloc_valid_i,
  input  logic [IQ_INDEX-1:0] alloc_idx_i,
  input  logic [IQ_SIZE-1:0]  ready_set_i,
  input  logic [IQ_SIZE-1:0]  grant_i,
  input  logic [IQ_SIZE-1:0]  replay_i,
  input  logic                flush_i,
  output logic [IQ_SIZE-1:0]  req_o,
  output logic                grantValid_o,
  output logic [IQ_INDEX-1:0] grantIdx_o,
  output logic [IQ_INDEX:0]   freeCount_o,
  output logic                error_o
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  entry_state_e        state_q [IQ_SIZE];
  entry_state_e        state_d [IQ_SIZE];

`ifdef IQ_REPLAY_EN
  logic [CNT_W-1:0]    cnt_q [IQ_SIZE];
  logic [CNT_W-1:0]    cnt_d [IQ_SIZE];
`else
  // Replay inputs and delay have no effect in this build.
  logic                unused_replay;
  assign unused_replay = ^{replay_i, CNT_W'(REPLAY_DELAY)};
`endif

  logic                grantValid_q, grantValid_d;
  logic [IQ_INDEX-1:0] grantIdx_q,   grantIdx_d;
  logic [IQ_INDEX:0]   freeCount_q,  freeCount_d;
  logic                error_q,      error_d;

  // --------------------------------------------------------------------------
  // Grant decode
  // --------------------------------------------------------------------------
  logic [IQ_INDEX-1:0] w_grant_idx;
  logic                w_grant_zero;
  logic                w_grant_multi;
  logic                w_grant_hit;
  logic                w_grant_err;
  logic [IQ_SIZE-1:0]  w_grant_sel;

  grant_encoder #(
    .WIDTH (IQ_SIZE),
    .IDX_W (IQ_INDEX)
  ) u_grant_enc (
    .vec_i   (grant_i),
    .idx_o   (w_grant_idx),
    .zero_o  (w_grant_zero),
    .multi_o (w_grant_multi)
  );

  // A grant is honoured only when it is exactly one-hot and lands on an
  // entry that is actually requesting; anything else nonzero is a protocol
  // violation and changes no state.
  assign w_grant_hit = !w_grant_zero && !w_grant_multi
                       && (state_q[w_grant_idx] == ST_REQ);
  assign w_grant_err = !w_grant_zero && !w_grant_hit;
  assign w_grant_sel = grant_i & {IQ_SIZE{w_grant_hit}};

  // --------------------------------------------------------------------------
  // Allocate decode
  // --------------------------------------------------------------------------
  logic [IQ_SIZE-1:0]  w_alloc_sel;
  logic                w_alloc_err;

  assign w_alloc_sel = {{(IQ_SIZE-1){1'b0}}, alloc_valid_i} << alloc_idx_i;
  assign w_alloc_err = alloc_valid_i && (state_q[alloc_idx_i] != ST_FREE);

  // --------------------------------------------------------------------------
  // Request vector: pure decode of the state flops, no input paths.
  // --------------------------------------------------------------------------
  always_comb begin
    req_o = '0;
    for (int i = 0; i < IQ_SIZE; i++) begin
      req_o[i] = (state_q[i] == ST_REQ);
    end
  end

  // Per-entry next state; flush overrides every other event.
  always_comb begin
    for (int i = 0; i < IQ_SIZE; i++) begin
      state_d[i] = state_q[i];
`ifdef IQ_REPLAY_EN
      cnt_d[i]   = cnt_q[i];
`endif
      case (state_q[i])
        ST_FREE: begin
          // Alloc with a same-cycle wakeup goes straight to requesting.
          if (w_alloc_sel[i]) begin
            state_d[i] = ready_set_i[i] ? ST_REQ : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ready_set_i[i]) begin
            state_d[i] = ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_grant_sel[i]) begin
`ifdef IQ_REPLAY_EN
            state_d[i] = ST_ISSUED;
            cnt_d[i]   = CNT_W'(REPLAY_DELAY);
`else
            state_d[i] = ST_FREE;
`endif
          end
        end
        ST_ISSUED: begin
`ifdef IQ_REPLAY_EN
          // Replay wins over expiry; the entry frees on the cycle its
          // countdown would reach zero.
          if (replay_i[i]) begin
            state_d[i] = ST_WAIT;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] <= CNT_W'(1)) begin
            state_d[i] = ST_FREE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] - CNT_W'(1);
          end
`else
          // Unreachable without replay; recover to FREE.
          state_d[i] = ST_FREE;
`endif
        end
      endcase

      if (flush_i) begin
        state_d[i] = ST_FREE;
`ifdef IQ_REPLAY_EN
        cnt_d[i]   = '0;
`endif
      end
    end
  end

  // Issue report, free-entry count and sticky error for the next cycle.
  always_comb begin
    grantValid_d = !flush_i && w_grant_hit;
    grantIdx_d   = grantValid_d ? w_grant_idx : grantIdx_q;
    error_d      = error_q || (!flush_i && (w_alloc_err || w_grant_err));
    freeCount_d  = '0;
    for (int i = 0; i < IQ_SIZE; i++) begin
      if (state_d[i] == ST_FREE) begin
        freeCount_d = freeCount_d + {{IQ_INDEX{1'b0}}, 1'b1};
      end
    end
  end

  // Entry state and replay counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < IQ_SIZE; i++) begin
        state_q[i] <= ST_FREE;
`ifdef IQ_REPLAY_EN
        cnt_q[i]   <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < IQ_SIZE; i++) begin
        state_q[i] <= state_d[i];
`ifdef IQ_REPLAY_EN
        cnt_q[i]   <= cnt_d[i];
`endif
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grantValid_q <= 1'b0;
      grantIdx_q   <= '0;
      freeCount_q  <= (IQ_INDEX+1)'(IQ_SIZE);
      error_q      <= 1'b0;
    end else begin
      grantValid_q <= grantValid_d;
      grantIdx_q   <= grantIdx_d;
      freeCount_q  <= freeCount_d;
      error_q      <= error_d;
    end
  end

  assign grantValid_o = grantValid_q;
  assign grantIdx_o   = grantIdx_q;
  assign freeCount_o  = freeCount_q;
  assign error_o      = error_q;

endmodule : issue_select_requester
`default_nettype wire
